alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 36 +++
 rtl/alarm_ctrl_bcd_min_add.sv | 47 ++++
 rtl/alarm_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types, BCD constants and helpers for the alarm controller.
// Optional snooze support is enabled with the ALARM_SNOOZE_EN macro (see alarm_ctrl).
package alarm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRinging,
        StSnoozed
    } state_e;

    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;

    // Alarm/target time after reset: 12:00 AM
    localparam logic [7:0] RST_AL_HH = BCD_12;
    localparam logic [7:0] RST_AL_MM = BCD_00;
    localparam logic       RST_AL_PM = 1'b0;

    // True when hh is 01..12 and mm is 00..59, every nibble a decimal digit
    function automatic logic bcd_time_valid(input logic [7:0] hh, input logic [7:0] mm);
        logic hh_ok;
        logic mm_ok;
        hh_ok = (hh[3:0] <= 4'd9) && (hh >= BCD_01) && (hh <= BCD_12);
        mm_ok = (mm[3:0] <= 4'd9) && (mm <= BCD_59);
        return hh_ok && mm_ok;
    endfunction

    // Converts a small integer (0..99) to packed BCD
    function automatic logic [7:0] int_to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_min_add.sv
// bcd_min_add: adds a BCD minute count to a 12-hour BCD time, wrapping minutes
// into the hour and the hour into AM/PM. Purely combinational.
module bcd_min_add
    import alarm_pkg::*;
(
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic       pm,
    input  logic [7:0] add,
    output logic [7:0] sum_hh,
    output logic [7:0] sum_mm,
    output logic       sum_pm
);

    logic [4:0] lo;
    logic [4:0] hi;
    logic       lo_carry;
    logic       hr_carry;

    // Digit-wise BCD minute add, then conditional hour increment
    always_comb begin
        lo       = {1'b0, mm[3:0]} + {1'b0, add[3:0]};
        lo_carry = (lo > 5'd9);
        if (lo_carry) lo = lo - 5'd10;
        hi       = {1'b0, mm[7:4]} + {1'b0, add[7:4]} + {4'b0, lo_carry};
        hr_carry = (hi >= 5'd6);
        if (hr_carry) hi = hi - 5'd6;
        sum_mm   = {hi[3:0], lo[3:0]};

        sum_hh = hh;
        sum_pm = pm;
        if (hr_carry) begin
            if (hh == BCD_12) begin
                sum_hh = BCD_01;
            end else if (hh == 8'h11) begin
                // 11 -> 12 crosses noon/midnight
                sum_hh = BCD_12;
                sum_pm = ~pm;
            end else if (hh[3:0] == 4'd9) begin
                sum_hh = {hh[7:4] + 4'd1, 4'd0};
            end else begin
                sum_hh = {hh[7:4], hh[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: compares the running 12-hour BCD clock with a stored alarm time and
// drives ringing, with stop, ring timeout and (when ALARM_SNOOZE_EN is defined)
// snooze with a limited number of repeats per alarm event.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 9,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       arm,
    input  logic       set_alarm,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    input  logic       stop,
    input  logic       snooze,
    output logic       ringing,
    output logic       armed,
    output logic       snoozed,
    output logic       set_err
);

    state_e     state_q, state_d;
    logic [7:0] al_hh_q, al_hh_d, al_mm_q, al_mm_d;
    logic       al_pm_q, al_pm_d;
    logic [7:0] tg_hh_q, tg_hh_d, tg_mm_q, tg_mm_d;
    logic       tg_pm_q, tg_pm_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       ringing_d, armed_d, snoozed_d, set_err_d;
    logic       match;
    logic       do_stop;

    assign match = ena && (hh == tg_hh_q) && (mm == tg_mm_q) && (pm == tg_pm_q)
                   && (ss == BCD_00);

`ifdef ALARM_SNOOZE_EN
    localparam logic [7:0] SnoozeBcd = int_to_bcd(SNOOZE_MIN);

    logic [2:0] snz_cnt_q, snz_cnt_d;
    logic [7:0] snz_hh, snz_mm;
    logic       snz_pm;
    logic       snz_ok;

    assign snz_ok = (snz_cnt_q < 3'(MAX_SNOOZE));

    bcd_min_add u_snooze_add (
        .hh     (hh),
        .mm     (mm),
        .pm     (pm),
        .add    (SnoozeBcd),
        .sum_hh (snz_hh),
        .sum_mm (snz_mm),
        .sum_pm (snz_pm)
    );
`else
    logic unused_snooze;
    assign unused_snooze = ^{snooze, 8'(SNOOZE_MIN), 3'(MAX_SNOOZE)};
`endif

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            al_hh_q    <= RST_AL_HH;
            al_mm_q    <= RST_AL_MM;
            al_pm_q    <= RST_AL_PM;
            tg_hh_q    <= RST_AL_HH;
            tg_mm_q    <= RST_AL_MM;
            tg_pm_q    <= RST_AL_PM;
            ring_cnt_q <= 8'd0;
            ringing    <= 1'b0;
            armed      <= 1'b0;
            snoozed    <= 1'b0;
            set_err    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            al_pm_q    <= al_pm_d;
            tg_hh_q    <= tg_hh_d;
            tg_mm_q    <= tg_mm_d;
            tg_pm_q    <= tg_pm_d;
            ring_cnt_q <= ring_cnt_d;
            ringing    <= ringing_d;
            armed      <= armed_d;
            snoozed    <= snoozed_d;
            set_err    <= set_err_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    // Next-state and register updates, in decreasing priority
    always_comb begin
        state_d    = state_q;
        al_hh_d    = al_hh_q;
        al_mm_d    = al_mm_q;
        al_pm_d    = al_pm_q;
        tg_hh_d    = tg_hh_q;
        tg_mm_d    = tg_mm_q;
        tg_pm_d    = tg_pm_q;
        ring_cnt_d = ring_cnt_q;
        set_err_d  = 1'b0;
        do_stop    = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        if (set_alarm) begin
            if (bcd_time_valid(alarm_hh, alarm_mm)) begin
                al_hh_d = alarm_hh;
                al_mm_d = alarm_mm;
                al_pm_d = alarm_pm;
                tg_hh_d = alarm_hh;
                tg_mm_d = alarm_mm;
                tg_pm_d = alarm_pm;
                state_d = arm ? StArmed : StIdle;
`ifdef ALARM_SNOOZE_EN
                snz_cnt_d = 3'd0;
`endif
            end else begin
                set_err_d = 1'b1;
                if (!arm) state_d = StIdle;
            end
        end else if (!arm) begin
            // Disarming cancels the current event, so re-arming waits for the alarm time
            state_d = StIdle;
            tg_hh_d = al_hh_q;
            tg_mm_d = al_mm_q;
            tg_pm_d = al_pm_q;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_d = 3'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: state_d = StArmed;
                StArmed: begin
                    if (match) begin
                        state_d    = StRinging;
                        ring_cnt_d = 8'd0;
                    end
                end
                StRinging: begin
                    if (stop) begin
                        do_stop = 1'b1;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze && snz_ok) begin
                        state_d   = StSnoozed;
                        tg_hh_d   = snz_hh;
                        tg_mm_d   = snz_mm;
                        tg_pm_d   = snz_pm;
                        snz_cnt_d = snz_cnt_q + 3'd1;
`endif
                    end else if (ena) begin
                        ring_cnt_d = ring_cnt_q + 8'd1;
                        if (ring_cnt_d == 8'(RING_SECS)) do_stop = 1'b1;
                    end
                end
                StSnoozed: begin
                    if (stop) begin
                        do_stop = 1'b1;
                    end else if (match) begin
                        state_d    = StRinging;
                        ring_cnt_d = 8'd0;
                    end
                end
            endcase
            if (do_stop) begin
                state_d = StArmed;
                tg_hh_d = al_hh_q;
                tg_mm_d = al_mm_q;
                tg_pm_d = al_pm_q;
`ifdef ALARM_SNOOZE_EN
                snz_cnt_d = 3'd0;
`endif
            end
        end
    end

    // Status outputs decoded from the next state so they register with it
    always_comb begin
        ringing_d = (state_d == StRinging);
        armed_d   = (state_d != StIdle);
`ifdef ALARM_SNOOZE_EN
        snoozed_d = (state_d == StSnoozed);
`else
        snoozed_d = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl. Observed vector is {ringing, armed, snoozed, set_err}.
// Snooze sequences are exercised when ALARM_SNOOZE_EN is defined.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset, ena, pm, arm, set_alarm, alarm_pm, stop, snooze;
    logic [7:0] hh, mm, ss, alarm_hh, alarm_mm;
    logic       ringing, armed, snoozed, set_err;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .RING_SECS  (60),
        .SNOOZE_MIN (9),
        .MAX_SNOOZE (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .pm        (pm),
        .arm       (arm),
        .set_alarm (set_alarm),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_pm  (alarm_pm),
        .stop      (stop),
        .snooze    (snooze),
        .ringing   (ringing),
        .armed     (armed),
        .snoozed   (snoozed),
        .set_err   (set_err)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {ringing, armed, snoozed, set_err};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: ring/arm/snz/err observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic p);
        hh = h; mm = m; ss = s; pm = p; ena = 1'b1;
        cyc();
        ena = 1'b0;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic p);
        alarm_hh = h; alarm_mm = m; alarm_pm = p; set_alarm = 1'b1;
        cyc();
        set_alarm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; arm = 1'b0; set_alarm = 1'b0; stop = 1'b0; snooze = 1'b0;
        hh = 8'h12; mm = 8'h00; ss = 8'h00; pm = 1'b0;
        alarm_hh = 8'h12; alarm_mm = 8'h00; alarm_pm = 1'b0;
        cyc(); cyc();
        check("reset", 4'b0000);
        reset = 1'b0;
        cyc();
        check("idle_unarmed", 4'b0000);
        arm = 1'b1;
        cyc();
        check("arm", 4'b0100);

        // Rejected loads
        load(8'h13, 8'h00, 1'b0);
        check("bad_hour", 4'b0101);
        cyc();
        check("err_one_cycle", 4'b0100);
        load(8'h06, 8'h5A, 1'b0);
        check("bad_min", 4'b0101);
        load(8'h00, 8'h10, 1'b0);
        check("bad_zero_hour", 4'b0101);
        cyc();
        tick(8'h12, 8'h00, 8'h00, 1'b0);
        check("reset_target_match", 4'b1100);
        pulse_stop();
        check("stop", 4'b0100);
        pulse_stop();
        check("stop_in_armed", 4'b0100);

        // 06:30 AM alarm with ring timeout
        load(8'h06, 8'h30, 1'b0);
        check("load_0630", 4'b0100);
        tick(8'h06, 8'h29, 8'h59, 1'b0);
        check("no_match_early", 4'b0100);
        tick(8'h06, 8'h30, 8'h00, 1'b1);
        check("pm_mismatch", 4'b0100);
        tick(8'h06, 8'h30, 8'h00, 1'b0);
        check("ring_0630", 4'b1100);
        cyc(); cyc();
        for (int s = 1; s < 60; s++) tick(8'h06, 8'h30, to_bcd(s), 1'b0);
        check("ring_hold_59", 4'b1100);
        tick(8'h06, 8'h31, 8'h00, 1'b0);
        check("ring_timeout", 4'b0100);

        // Disarm mid-ring and re-arm
        tick(8'h06, 8'h30, 8'h00, 1'b0);
        check("ring_again", 4'b1100);
        arm = 1'b0;
        cyc();
        check("arm_drop", 4'b0000);
        tick(8'h06, 8'h30, 8'h00, 1'b0);
        check("disarmed_no_ring", 4'b0000);
        arm = 1'b1;
        cyc();
        check("rearm", 4'b0100);
        tick(8'h06, 8'h30, 8'h00, 1'b0);
        check("rearm_ring", 4'b1100);

`ifdef ALARM_SNOOZE_EN
        pulse_stop();
        load(8'h11, 8'h55, 1'b1);
        check("load_1155pm", 4'b0100);
        tick(8'h11, 8'h55, 8'h00, 1'b1);
        check("ring_1155pm", 4'b1100);
        pulse_snooze();
        check("snooze1", 4'b0110);
        tick(8'h12, 8'h03, 8'h00, 1'b0);
        check("snz_early", 4'b0110);
        tick(8'h12, 8'h04, 8'h00, 1'b1);
        check("snz_pm_wrong", 4'b0110);
        tick(8'h12, 8'h04, 8'h00, 1'b0);
        check("snz_ring1", 4'b1100);
        pulse_snooze();
        check("snooze2", 4'b0110);
        tick(8'h12, 8'h13, 8'h00, 1'b0);
        check("snz_ring2", 4'b1100);
        pulse_snooze();
        check("snooze3", 4'b0110);
        tick(8'h12, 8'h22, 8'h00, 1'b0);
        check("snz_ring3", 4'b1100);
        pulse_snooze();
        check("snooze4_ignored", 4'b1100);
        pulse_stop();
        check("stop_after_snooze", 4'b0100);
        tick(8'h11, 8'h55, 8'h00, 1'b1);
        check("target_restored", 4'b1100);
        stop = 1'b1; snooze = 1'b1;
        cyc();
        stop = 1'b0; snooze = 1'b0;
        check("stop_beats_snooze", 4'b0100);
        tick(8'h11, 8'h55, 8'h00, 1'b1);
        pulse_snooze();
        check("snooze_after_stop", 4'b0110);
        reset = 1'b1;
        cyc();
        check("reset_in_snoozed", 4'b0000);
        reset = 1'b0;
        cyc();
        check("armed_after_reset", 4'b0100);
        tick(8'h12, 8'h00, 8'h00, 1'b0);
        check("reset_target", 4'b1100);
        pulse_stop();
        load(8'h12, 8'h55, 1'b1);
        tick(8'h12, 8'h55, 8'h00, 1'b1);
        pulse_snooze();
        tick(8'h01, 8'h04, 8'h00, 1'b1);
        check("snz_hour_12_to_01", 4'b1100);
        pulse_stop();
        load(8'h09, 8'h58, 1'b0);
        tick(8'h09, 8'h58, 8'h00, 1'b0);
        pulse_snooze();
        tick(8'h10, 8'h07, 8'h00, 1'b0);
        check("snz_hour_09_to_10", 4'b1100);
`else
        pulse_snooze();
        check("snooze_ignored", 4'b1100);
        reset = 1'b1;
        cyc();
        check("reset_mid_ring", 4'b0000);
        reset = 1'b0;
        cyc();
        check("armed_after_reset", 4'b0100);
        tick(8'h12, 8'h00, 8'h00, 1'b0);
        check("reset_target", 4'b1100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
